// File: rtl/mmcm_reconfig_ctrl.sv
// Applies a software-loaded table of DRP read-modify-write entries to the MMCM
// while holding it in reset, then releases reset and waits for lock.
module mmcm_reconfig_ctrl #(
  parameter int DEPTH   = 8,
  parameter int AW      = 11,
  parameter int DRDY_TO = 255,
  parameter int LOCK_TO = 65535
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       tbl_wen,
  input  logic [$clog2(DEPTH)-1:0]   tbl_waddr,
  input  logic [AW+31:0]             tbl_wdata,
  input  logic                       i_start,
  input  logic [$clog2(DEPTH):0]     i_num,
  output logic [AW-1:0]              o_daddr,
  output logic                       o_den,
  output logic                       o_dwe,
  output logic [15:0]                o_din,
  input  logic [15:0]                i_dout,
  input  logic                       i_drdy,
  output logic                       o_mmcm_rst,
  input  logic                       i_locked,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [1:0]                 o_err_code
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2((LOCK_TO > DRDY_TO ? LOCK_TO : DRDY_TO) + 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TO - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TO - 1);
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [IW:0]   NUM_ONE   = 1;
  localparam logic [IW-1:0] IDX_ONE   = 1;
  localparam logic [1:0]    ERR_DRDY  = 2'd1;
  localparam logic [1:0]    ERR_LOCK  = 2'd2;

  typedef enum logic [2:0] {
    IDLE, RST_ON, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RST_OFF, LOCK_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW:0]     num_q, num_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   daddr_q, daddr_d;
  logic            den_q, den_d;
  logic            dwe_q, dwe_d;
  logic [15:0]     din_q, din_d;
  logic            mmcm_rst_q, mmcm_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;

  logic [AW+31:0]  tbl_q [DEPTH];
  logic [IW-1:0]   nxt_idx;
  logic [AW-1:0]   first_addr, nxt_addr;
  logic [15:0]     cur_mask, cur_data;
  logic            last_entry;

  always_ff @(posedge i_clk) begin
    if (tbl_wen && !busy_q) tbl_q[tbl_waddr] <= tbl_wdata;
  end

  // Table is frozen while busy, so entry fields can be read directly from it.
  assign nxt_idx    = idx_q + IDX_ONE;
  assign first_addr = tbl_q[0][AW+31:32];
  assign nxt_addr   = tbl_q[nxt_idx][AW+31:32];
  assign cur_mask   = tbl_q[idx_q][31:16];
  assign cur_data   = tbl_q[idx_q][15:0];
  assign last_entry = ({1'b0, idx_q} == (num_q - NUM_ONE));

  // Outputs are registered from the next state, so each is valid for the
  // whole cycle of the state it belongs to.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    daddr_d    = daddr_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    din_d      = din_q;
    mmcm_rst_d = mmcm_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          num_d      = i_num;
          err_d      = 1'b0;
          err_code_d = '0;
          busy_d     = 1'b1;
          mmcm_rst_d = 1'b1;
          state_d    = RST_ON;
        end
      end
      RST_ON: begin
        if (num_q == '0) begin
          mmcm_rst_d = 1'b0;
          cnt_d      = '0;
          state_d    = RST_OFF;
        end else begin
          idx_d   = '0;
          daddr_d = first_addr;
          den_d   = 1'b1;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_drdy) begin
          din_d   = (i_dout & cur_mask) | (cur_data & ~cur_mask);
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          state_d = WR_REQ;
        end else if (cnt_q == DRDY_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_DRDY;
          mmcm_rst_d = 1'b0;
          cnt_d      = '0;
          state_d    = RST_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WR_REQ: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (i_drdy) begin
          if (last_entry) begin
            mmcm_rst_d = 1'b0;
            cnt_d      = '0;
            state_d    = RST_OFF;
          end else begin
            idx_d   = nxt_idx;
            daddr_d = nxt_addr;
            den_d   = 1'b1;
            state_d = RD_REQ;
          end
        end else if (cnt_q == DRDY_LAST) begin
          err_d      = 1'b1;
          err_code_d = ERR_DRDY;
          mmcm_rst_d = 1'b0;
          cnt_d      = '0;
          state_d    = RST_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RST_OFF: begin
        cnt_d   = '0;
        state_d = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (i_locked) begin
          busy_d  = 1'b0;
          done_d  = !err_q;
          state_d = IDLE;
        end else if (cnt_q == LOCK_LAST) begin
          err_d = 1'b1;
          if (err_code_q != ERR_DRDY) err_code_d = ERR_LOCK;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
      daddr_q    <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      din_q      <= '0;
      mmcm_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      din_q      <= din_d;
      mmcm_rst_q <= mmcm_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_daddr    = daddr_q;
  assign o_den      = den_q;
  assign o_dwe      = dwe_q;
  assign o_din      = din_q;
  assign o_mmcm_rst = mmcm_rst_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_err_code = err_code_q;

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Directed bench for mmcm_reconfig_ctrl with a behavioural DRP/MMCM model.
module tb_mmcm_reconfig_ctrl;

  localparam int DEPTH   = 8;
  localparam int AW      = 11;
  localparam int DRDY_TO = 20;
  localparam int LOCK_TO = 100;

  logic           clk = 1'b0;
  logic           i_resetn = 1'b0;
  logic           tbl_wen = 1'b0;
  logic [2:0]     tbl_waddr = '0;
  logic [AW+31:0] tbl_wdata = '0;
  logic           i_start = 1'b0;
  logic [3:0]     i_num = '0;
  logic [AW-1:0]  o_daddr;
  logic           o_den, o_dwe;
  logic [15:0]    o_din;
  logic [15:0]    i_dout = '0;
  logic           i_drdy = 1'b0;
  logic           o_mmcm_rst;
  logic           i_locked = 1'b0;
  logic           o_busy, o_done, o_err;
  logic [1:0]     o_err_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmcm_reconfig_ctrl #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .DRDY_TO(DRDY_TO),
    .LOCK_TO(LOCK_TO)
  ) dut (
    .i_clk     (clk),
    .i_resetn  (i_resetn),
    .tbl_wen   (tbl_wen),
    .tbl_waddr (tbl_waddr),
    .tbl_wdata (tbl_wdata),
    .i_start   (i_start),
    .i_num     (i_num),
    .o_daddr   (o_daddr),
    .o_den     (o_den),
    .o_dwe     (o_dwe),
    .o_din     (o_din),
    .i_dout    (i_dout),
    .i_drdy    (i_drdy),
    .o_mmcm_rst(o_mmcm_rst),
    .i_locked  (i_locked),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_err_code(o_err_code)
  );

  // DRP register file, access log and MMCM lock model
  logic [15:0]   mem [2048];
  logic          lock_en = 1'b1;
  int            drop_read = 0;
  int            rd_count = 0;
  logic          pend = 1'b0;
  logic [15:0]   pend_dout = '0;
  int            lock_cnt = 0;
  int            log_n = 0;
  logic          log_we [64];
  logic [AW-1:0] log_addr [64];
  logic [15:0]   log_din [64];

  // stimulus extras used by run_seq
  int            inj_cyc = 0;
  logic [AW+31:0] inj_data = '0;
  logic          ws_en = 1'b0;
  logic [AW+31:0] ws_data = '0;

  always @(negedge clk) begin
    i_drdy = pend;
    i_dout = pend_dout;
    pend   = 1'b0;
    if (o_den) begin
      if (log_n < 64) begin
        log_we[log_n]   = o_dwe;
        log_addr[log_n] = o_daddr;
        log_din[log_n]  = o_din;
        log_n++;
      end
      if (o_dwe) begin
        mem[o_daddr] = o_din;
        pend = 1'b1;
      end else begin
        rd_count++;
        pend_dout = mem[o_daddr];
        pend = (rd_count != drop_read);
      end
    end
    if (o_mmcm_rst) begin
      lock_cnt = 0;
      i_locked = 1'b0;
    end else if (lock_cnt < 10) begin
      lock_cnt++;
    end else begin
      i_locked = lock_en;
    end
  end

  function automatic logic [AW+31:0] ent(input logic [AW-1:0] a, input logic [15:0] m,
                                         input logic [15:0] d);
    return {a, m, d};
  endfunction

  task automatic load(input logic [2:0] idx, input logic [AW+31:0] e);
    @(negedge clk);
    tbl_wen = 1'b1; tbl_waddr = idx; tbl_wdata = e;
    @(negedge clk);
    tbl_wen = 1'b0;
  endtask

  // c counts negedges after the edge that accepts the start.
  task automatic run_seq(input logic [3:0] num, output int rst_fall, output int rst_cycles,
                         output logic saw_done, output int den_bad, output logic timed_out);
    logic prev_den, prev_rst;
    for (int k = 0; k < 64; k++) begin
      log_we[k] = 1'bx; log_addr[k] = 'x; log_din[k] = 'x;
    end
    log_n = 0; rd_count = 0;
    @(negedge clk);
    i_start = 1'b1; i_num = num;
    if (ws_en) begin
      tbl_wen = 1'b1; tbl_waddr = '0; tbl_wdata = ws_data;
    end
    rst_fall = -1; rst_cycles = 0; saw_done = 1'b0; den_bad = 0; timed_out = 1'b1;
    prev_den = 1'b0; prev_rst = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      i_start = 1'b0; tbl_wen = 1'b0;
      if (c == inj_cyc) begin
        i_start = 1'b1; i_num = 4'd3;
        tbl_wen = 1'b1; tbl_waddr = '0; tbl_wdata = inj_data;
      end
      if (o_den && prev_den) den_bad++;
      if (o_dwe && !o_den) den_bad++;
      prev_den = o_den;
      if (o_mmcm_rst) rst_cycles++;
      if (prev_rst && !o_mmcm_rst && rst_fall < 0) rst_fall = c;
      prev_rst = o_mmcm_rst;
      if (o_done) saw_done = 1'b1;
      if (!o_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    i_start = 1'b0; tbl_wen = 1'b0;
  endtask

  task automatic test_reset();
    i_resetn = 1'b0;
    #12;
    total++;
    if ({o_daddr, o_den, o_dwe, o_din, o_mmcm_rst, o_busy, o_done, o_err, o_err_code} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got daddr=%h den=%b dwe=%b din=%h rst=%b busy=%b done=%b err=%b code=%0d want all 0",
               o_daddr, o_den, o_dwe, o_din, o_mmcm_rst, o_busy, o_done, o_err, o_err_code);
    end
    @(negedge clk); i_resetn = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({o_den, o_mmcm_rst, o_busy, o_done, o_err} !== 5'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got den=%b rst=%b busy=%b done=%b err=%b want 0",
               o_den, o_mmcm_rst, o_busy, o_done, o_err);
    end
  endtask

  task automatic test_single();
    int rf, rc, db; logic dn, to;
    mem[11'h08] = 16'h1234;
    load(3'd0, ent(11'h08, 16'h1000, 16'h0041));
    run_seq(4'd1, rf, rc, dn, db, to);
    total++;
    if (to) begin bad++; $display("FAIL single_wait: busy still %b want 0", o_busy); end
    total++;
    if (log_n !== 2) begin bad++; $display("FAIL single_nacc: got %0d want 2", log_n); end
    total++;
    if (log_we[0] !== 1'b0 || log_addr[0] !== 11'h08) begin
      bad++; $display("FAIL single_rd: got we=%b addr=%h want we=0 addr=008", log_we[0], log_addr[0]);
    end
    total++;
    if (log_we[1] !== 1'b1 || log_addr[1] !== 11'h08 || log_din[1] !== 16'h1041) begin
      bad++; $display("FAIL single_wr: got we=%b addr=%h din=%h want we=1 addr=008 din=1041",
                      log_we[1], log_addr[1], log_din[1]);
    end
    total++;
    if (rf !== 6 || rc !== 5) begin
      bad++; $display("FAIL single_rst: got fall=%0d high=%0d want fall=6 high=5", rf, rc);
    end
    total++;
    if (dn !== 1'b1 || o_err !== 1'b0 || db !== 0) begin
      bad++; $display("FAIL single_done: got done=%b err=%b denbad=%0d want 1 0 0", dn, o_err, db);
    end
  endtask

  task automatic test_three();
    int rf, rc, db; logic dn, to;
    logic          ew [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ea [6] = '{11'h08, 11'h08, 11'h09, 11'h09, 11'h14, 11'h14};
    logic [15:0]   ed [6] = '{16'h0, 16'h1041, 16'h0, 16'h5AAA, 16'h0, 16'hBEEF};
    mem[11'h08] = 16'h1234; mem[11'h09] = 16'h5A5A; mem[11'h14] = 16'hFFFF;
    load(3'd0, ent(11'h08, 16'h1000, 16'h0041));
    load(3'd1, ent(11'h09, 16'hFF00, 16'h00AA));
    load(3'd2, ent(11'h14, 16'h0000, 16'hBEEF));
    run_seq(4'd3, rf, rc, dn, db, to);
    total++;
    if (to || log_n !== 6) begin
      bad++; $display("FAIL three_nacc: got %0d timeout=%b want 6 0", log_n, to);
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (log_we[k] !== ew[k] || log_addr[k] !== ea[k] || (ew[k] && log_din[k] !== ed[k])) begin
        bad++;
        $display("FAIL three_acc%0d: got we=%b addr=%h din=%h want we=%b addr=%h din=%h",
                 k, log_we[k], log_addr[k], log_din[k], ew[k], ea[k], ed[k]);
      end
    end
    total++;
    if (rf !== 14) begin bad++; $display("FAIL three_latency: got %0d want 14", rf); end
    total++;
    if (db !== 0 || dn !== 1'b1 || o_err !== 1'b0) begin
      bad++; $display("FAIL three_done: got denbad=%0d done=%b err=%b want 0 1 0", db, dn, o_err);
    end
  endtask

  task automatic test_num_zero();
    int rf, rc, db; logic dn, to;
    run_seq(4'd0, rf, rc, dn, db, to);
    total++;
    if (log_n !== 0) begin bad++; $display("FAIL zero_nacc: got %0d want 0", log_n); end
    total++;
    if (rc !== 1 || rf !== 2) begin
      bad++; $display("FAIL zero_rst: got high=%0d fall=%0d want 1 2", rc, rf);
    end
    total++;
    if (to || dn !== 1'b1 || o_err !== 1'b0) begin
      bad++; $display("FAIL zero_done: got timeout=%b done=%b err=%b want 0 1 0", to, dn, o_err);
    end
  endtask

  task automatic test_drdy_timeout();
    int rf, rc, db; logic dn, to;
    mem[11'h08] = 16'h1234; mem[11'h09] = 16'h5A5A; mem[11'h14] = 16'hFFFF;
    drop_read = 2;
    run_seq(4'd3, rf, rc, dn, db, to);
    drop_read = 0;
    total++;
    if (log_n !== 3 || log_addr[2] !== 11'h09 || log_we[2] !== 1'b0) begin
      bad++; $display("FAIL drdy_nacc: got n=%0d last=%h we=%b want 3 009 0", log_n, log_addr[2], log_we[2]);
    end
    total++;
    if (o_err !== 1'b1 || o_err_code !== 2'd1) begin
      bad++; $display("FAIL drdy_err: got err=%b code=%0d want 1 1", o_err, o_err_code);
    end
    total++;
    if (to || dn !== 1'b0 || o_mmcm_rst !== 1'b0) begin
      bad++; $display("FAIL drdy_end: got timeout=%b done=%b rst=%b want 0 0 0", to, dn, o_mmcm_rst);
    end
    total++;
    if (rf < 7 + DRDY_TO - 1 || rf > 7 + DRDY_TO + 1) begin
      bad++; $display("FAIL drdy_time: got fall=%0d want %0d +-1", rf, 7 + DRDY_TO);
    end
  endtask

  task automatic test_lock_timeout();
    int rf, rc, db; logic dn, to;
    load(3'd0, ent(11'h08, 16'h1000, 16'h0041));
    lock_en = 1'b0;
    run_seq(4'd1, rf, rc, dn, db, to);
    lock_en = 1'b1;
    total++;
    if (o_err !== 1'b1 || o_err_code !== 2'd2) begin
      bad++; $display("FAIL lock_err: got err=%b code=%0d want 1 2", o_err, o_err_code);
    end
    total++;
    if (to || o_busy !== 1'b0 || dn !== 1'b0) begin
      bad++; $display("FAIL lock_end: got timeout=%b busy=%b done=%b want 0 0 0", to, o_busy, dn);
    end
    run_seq(4'd1, rf, rc, dn, db, to);
    total++;
    if (to || o_err !== 1'b0 || o_err_code !== 2'd0 || dn !== 1'b1) begin
      bad++; $display("FAIL lock_retry: got timeout=%b err=%b code=%0d done=%b want 0 0 0 1",
                      to, o_err, o_err_code, dn);
    end
  endtask

  task automatic test_busy_ignore();
    int rf, rc, db; logic dn, to;
    mem[11'h08] = 16'h0000;
    load(3'd0, ent(11'h08, 16'h0000, 16'h1111));
    inj_cyc = 3; inj_data = ent(11'h30, 16'h0000, 16'h2222);
    run_seq(4'd1, rf, rc, dn, db, to);
    inj_cyc = 0;
    total++;
    if (to || log_n !== 2 || dn !== 1'b1) begin
      bad++; $display("FAIL busy_start: got n=%0d done=%b timeout=%b want 2 1 0", log_n, dn, to);
    end
    run_seq(4'd1, rf, rc, dn, db, to);
    total++;
    if (log_addr[0] !== 11'h08 || log_addr[1] !== 11'h08 || log_din[1] !== 16'h1111) begin
      bad++; $display("FAIL busy_tbl: got addr=%h/%h din=%h want 008/008 1111",
                      log_addr[0], log_addr[1], log_din[1]);
    end
  endtask

  task automatic test_write_on_start();
    int rf, rc, db; logic dn, to;
    mem[11'h21] = 16'hAAAA;
    ws_en = 1'b1; ws_data = ent(11'h21, 16'h0000, 16'h7777);
    run_seq(4'd1, rf, rc, dn, db, to);
    ws_en = 1'b0;
    total++;
    if (log_addr[0] !== 11'h21 || log_we[1] !== 1'b1 || log_addr[1] !== 11'h21 || log_din[1] !== 16'h7777) begin
      bad++; $display("FAIL wstart: got addr=%h/%h we=%b din=%h want 021/021 1 7777",
                      log_addr[0], log_addr[1], log_we[1], log_din[1]);
    end
  endtask

  task automatic test_reset_mid();
    mem[11'h08] = 16'h1234;
    load(3'd0, ent(11'h08, 16'h1000, 16'h0041));
    @(negedge clk);
    i_start = 1'b1; i_num = 4'd1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (o_mmcm_rst !== 1'b1 || o_busy !== 1'b1 || o_din !== 16'h1041 || o_den !== 1'b0) begin
      bad++; $display("FAIL mid_pre: got rst=%b busy=%b din=%h den=%b want 1 1 1041 0",
                      o_mmcm_rst, o_busy, o_din, o_den);
    end
    i_resetn = 1'b0;
    #1;
    total++;
    if ({o_daddr, o_den, o_dwe, o_din, o_mmcm_rst, o_busy, o_done, o_err, o_err_code} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got daddr=%h den=%b dwe=%b din=%h rst=%b busy=%b done=%b err=%b code=%0d want all 0",
               o_daddr, o_den, o_dwe, o_din, o_mmcm_rst, o_busy, o_done, o_err, o_err_code);
    end
    @(negedge clk); i_resetn = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_mmcm_rst !== 1'b0 || o_den !== 1'b0) begin
      bad++; $display("FAIL mid_idle: got busy=%b rst=%b den=%b want 0 0 0", o_busy, o_mmcm_rst, o_den);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_num_zero();
    test_drdy_timeout();
    test_lock_timeout();
    test_busy_ignore();
    test_write_on_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmcm_reconfig_ctrl.md
Name: mmcm_reconfig_ctrl

Overview:
- Sequences dynamic reconfiguration of the MMCM behind the clock generator through its DRP port.
- Holds a small table of (DRP address, keep-mask, new value) entries loaded by software. On start it:
  - places the MMCM in reset,
  - performs a read-modify-write for each entry,
  - releases reset and waits for lock.
- Sits between the AXI-lite register block and the MMCM DRP, replacing direct register-to-DRP passthrough with one atomic, ordered sequence.

Parameters:
- DEPTH, 8: number of table entries (power of 2, 2..32).
- AW, 11: DRP address width.
- DRDY_TO, 255: maximum cycles to wait for drdy after a den pulse.
- LOCK_TO, 65535: maximum cycles to wait for locked after reset release.

Ports:
- i_clk  in  1  clock; also drives the DRP dclk.
- i_resetn  in  1  asynchronous active-low reset.
- tbl_wen  in  1  table write strobe; ignored while o_busy=1.
- tbl_waddr  in  log2(DEPTH)  table entry index.
- tbl_wdata  in  AW+32  {addr[AW-1:0], mask[15:0], data[15:0]}.
- i_start  in  1  one-cycle start request.
- i_num  in  log2(DEPTH)+1  number of entries to apply (0..DEPTH), sampled on accepted start.
- o_daddr  out  AW  DRP address.
- o_den  out  1  DRP enable, single-cycle pulse.
- o_dwe  out  1  DRP write enable, high only with o_den on writes.
- o_din  out  16  DRP write data.
- i_dout  in  16  DRP read data.
- i_drdy  in  1  DRP ready.
- o_mmcm_rst  out  1  MMCM reset, active high.
- i_locked  in  1  MMCM locked.
- o_busy  out  1  sequence in progress.
- o_done  out  1  one-cycle pulse on successful completion.
- o_err  out  1  sticky error flag, cleared on next accepted start.
- o_err_code  out  2  0 none, 1 drdy timeout, 2 lock timeout.

Behaviour:
- Reset values:
  - All outputs 0.
  - Table contents undefined.
  - FSM in IDLE.
  - Entry index 0; timeout counter 0.
- States: IDLE, RST_ON, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RST_OFF, LOCK_WAIT.
- IDLE:
  - i_start=1 accepts. Latch i_num, clear o_err/o_err_code, set o_busy, go RST_ON.
  - i_start while busy is ignored.
- RST_ON:
  - o_mmcm_rst=1 from this cycle until RST_OFF.
  - If num=0, go RST_OFF; else index=0, go RD_REQ.
- RD_REQ:
  - One cycle with o_den=1, o_dwe=0, o_daddr=entry.addr.
  - Go RD_WAIT; clear timeout counter.
- RD_WAIT:
  - On i_drdy, capture new=(i_dout & mask) | (data & ~mask); mask bit 1 means keep the existing bit. Go WR_REQ.
  - If counter reaches DRDY_TO without drdy, raise the error (code 1) and go RST_OFF.
- WR_REQ:
  - One cycle with o_den=1, o_dwe=1, o_daddr=entry.addr, o_din=new.
  - Go WR_WAIT.
- WR_WAIT:
  - On i_drdy: if index==num-1 go RST_OFF, else index+1 and go RD_REQ.
  - Timeout handled as in RD_WAIT.
- RST_OFF:
  - Deassert o_mmcm_rst; clear counter; go LOCK_WAIT.
  - The MMCM is never left in reset, even on error.
- LOCK_WAIT:
  - i_locked=1 with no error: pulse o_done, clear o_busy, go IDLE.
  - i_locked=1 with a drdy error: clear o_busy, no o_done, go IDLE.
  - Counter reaches LOCK_TO: raise the error (code 2, unless code 1 is already latched), clear o_busy, go IDLE.
  - i_locked is sampled only in this state. A stale locked level at the first LOCK_WAIT cycle is acceptable because the MMCM drops lock under reset.
- Control outputs:
  - o_den, o_dwe and o_din are registered.
  - o_din and o_daddr are held stable between requests; checks apply only when o_den=1.
- i_drdy outside RD_WAIT/WR_WAIT is ignored.
- Latency, N entries, zero-wait drdy (drdy one cycle after den): start to RST_OFF = 2 + 4N cycles.
- Table writes:
  - Take effect on the next clock.
  - A write in the same cycle as an accepted start is performed; the sequence then uses the updated table.
- Async reset mid-sequence returns to IDLE with o_mmcm_rst=0; the partial DRP write state is not recovered.

Test Plan:
- Load entry0={0x08, 0x1000, 0x0041}. Start num=1. Model dout=0x1234, drdy one cycle after den, locked 10 cycles after reset release.
  -> One read at 0x08, then one write at 0x08 with din=0x1041. o_mmcm_rst high throughout; o_done pulse; o_err=0.
- Load 3 entries (addrs 0x08, 0x09, 0x14). Start num=3.
  -> DRP accesses in order R08 W08 R09 W09 R14 W14. Each den is exactly one cycle.
  -> Start to reset release = 14 cycles with zero-wait drdy.
- Start num=0.
  -> No den. o_mmcm_rst is high for 1 cycle, then LOCK_WAIT; done follows locked.
- Model never asserts drdy on the second read.
  -> After DRDY_TO cycles: o_err=1, code=1, reset released, no o_done, o_busy drops after lock.
- Model never asserts locked.
  -> o_err=1, code=2 after LOCK_TO cycles; o_busy=0.
  -> A second start clears o_err and succeeds.
- Start pulse during busy, plus tbl_wen during busy.
  -> Both ignored: table readback via a later sequence shows the old values. Assert i_resetn=0 mid-WR_WAIT -> all outputs 0 immediately.
